// File: rtl/pipelined_barrel_shifter.sv
// Pipelined ARM operand-2 shifter (LSL/LSR/ASR/ROR/RRX, immediate and register amounts).
// Define BSHIFT_FLAGS_EN to add registered out_Zero/out_Neg result flags.
module pipelined_barrel_shifter #(
  parameter int WIDTH     = 32,
  parameter int AMT_WIDTH = 8,
  parameter int STAGES    = 2,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 in_Clk,
  input  logic                 in_Rst,
  input  logic                 in_Flush,
  input  logic                 in_Valid,
  output logic                 out_Ready,
  input  logic [WIDTH-1:0]     in_Val,
  input  logic [AMT_WIDTH-1:0] in_Amount,
  input  logic [1:0]           in_Shift_type,
  input  logic                 in_Reg_mode,
  input  logic                 in_C_flag,
  input  logic [TAG_WIDTH-1:0] in_Tag,
  output logic                 out_Valid,
  input  logic                 in_Ready,
  output logic [WIDTH-1:0]     out_Op2,
  output logic                 out_Carry,
  output logic [TAG_WIDTH-1:0] out_Tag
`ifdef BSHIFT_FLAGS_EN
  ,
  output logic                 out_Zero,
  output logic                 out_Neg
`endif
);

  localparam int LOG  = $clog2(WIDTH);
  localparam int BASE = LOG / STAGES;
  localparam int REM  = LOG % STAGES;
  localparam logic [AMT_WIDTH-1:0] AMT_W = AMT_WIDTH'(WIDTH);

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;

  // Level j shifts by WIDTH>>(j+1); earlier stages take the extra level when LOG doesn't divide evenly.
  function automatic int level_stage(input int j);
    if (j < REM * (BASE + 1)) return j / (BASE + 1);
    return REM + (j - REM * (BASE + 1)) / BASE;
  endfunction

  function automatic logic [WIDTH:0] shift_level(input logic [WIDTH-1:0] d,
                                                 input logic [1:0] typ, input int n);
    logic signed [WIDTH-1:0] sd;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] out_bits;
    sd = d;
    case (typ)
      LSL:     begin res = d << n;                       out_bits = d >> (WIDTH - n); end
      LSR:     begin res = d >> n;                       out_bits = d >> (n - 1);     end
      ASR:     begin res = sd >>> n;                     out_bits = d >> (n - 1);     end
      default: begin res = (d >> n) | (d << (WIDTH - n)); out_bits = d >> (n - 1);    end
    endcase
    return {out_bits[0], res};
  endfunction

  function automatic logic [WIDTH:0] apply_stage(input logic [WIDTH-1:0] d, input logic c,
                                                 input logic [LOG-1:0] amt,
                                                 input logic [1:0] typ, input int stg);
    logic [WIDTH:0] acc;
    logic [LOG-1:0] a;
    acc = {c, d};
    for (int j = 0; j < LOG; j++) begin
      a = amt >> (LOG - 1 - j);
      if (level_stage(j) == stg && a[0]) acc = shift_level(acc[WIDTH-1:0], typ, WIDTH >> (j + 1));
    end
    return acc;
  endfunction

  logic [WIDTH-1:0]     dec_d;
  logic                 dec_c;
  logic [LOG-1:0]       dec_amt;
  logic [LOG-1:0]       imm_a;
  logic                 zero_force, sign_fill, rrx;
  logic                 msb, lsb;

  logic [WIDTH-1:0]     data_p  [STAGES];
  logic                 carry_p [STAGES];
  logic [LOG-1:0]       amt_p   [STAGES];
  logic [1:0]           typ_p   [STAGES];
  logic [TAG_WIDTH-1:0] tag_p   [STAGES];
  logic [STAGES-1:0]    vld_p;

  logic [WIDTH-1:0]     src_d   [STAGES];
  logic                 src_c   [STAGES];
  logic [LOG-1:0]       src_amt [STAGES];
  logic [1:0]           src_typ [STAGES];
  logic [TAG_WIDTH-1:0] src_tag [STAGES];
  logic [STAGES-1:0]    src_vld;
  logic [WIDTH:0]       nxt     [STAGES];
  logic [STAGES-1:0]    take;

  // Amount-0 encodings and out-of-range register amounts collapse to a preset value and carry.
  always_comb begin
    imm_a      = in_Amount[LOG-1:0];
    msb        = in_Val[WIDTH-1];
    lsb        = in_Val[0];
    dec_c      = in_C_flag;
    dec_amt    = '0;
    zero_force = 1'b0;
    sign_fill  = 1'b0;
    rrx        = 1'b0;
    if (!in_Reg_mode) begin
      if (imm_a != '0) dec_amt = imm_a;
      else begin
        case (in_Shift_type)
          LSL:     dec_c = in_C_flag;
          LSR:     begin zero_force = 1'b1; dec_c = msb; end
          ASR:     begin sign_fill  = 1'b1; dec_c = msb; end
          default: begin rrx        = 1'b1; dec_c = lsb; end
        endcase
      end
    end else if (in_Amount != '0) begin
      case (in_Shift_type)
        LSL:
          if (in_Amount < AMT_W) dec_amt = imm_a;
          else begin zero_force = 1'b1; dec_c = (in_Amount == AMT_W) ? lsb : 1'b0; end
        LSR:
          if (in_Amount < AMT_W) dec_amt = imm_a;
          else begin zero_force = 1'b1; dec_c = (in_Amount == AMT_W) ? msb : 1'b0; end
        ASR:
          if (in_Amount < AMT_W) dec_amt = imm_a;
          else begin sign_fill = 1'b1; dec_c = msb; end
        default:
          if (imm_a == '0) dec_c = msb;
          else dec_amt = imm_a;
      endcase
    end
    dec_d = in_Val;
    if (zero_force)     dec_d = '0;
    else if (sign_fill) dec_d = {WIDTH{msb}};
    else if (rrx)       dec_d = {in_C_flag, in_Val[WIDTH-1:1]};
  end

  always_comb begin
    logic chain;
    chain = in_Ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain   = chain || !vld_p[k];
      take[k] = chain;
    end
  end

  assign out_Ready = !in_Flush && take[0];

  always_comb begin
    src_d[0]   = dec_d;
    src_c[0]   = dec_c;
    src_amt[0] = dec_amt;
    src_typ[0] = in_Shift_type;
    src_tag[0] = in_Tag;
    src_vld[0] = in_Valid && out_Ready;
    for (int k = 1; k < STAGES; k++) begin
      src_d[k]   = data_p[k-1];
      src_c[k]   = carry_p[k-1];
      src_amt[k] = amt_p[k-1];
      src_typ[k] = typ_p[k-1];
      src_tag[k] = tag_p[k-1];
      src_vld[k] = vld_p[k-1];
    end
    for (int k = 0; k < STAGES; k++)
      nxt[k] = apply_stage(src_d[k], src_c[k], src_amt[k], src_typ[k], k);
  end

  // Stage registers: each stage loads when it is empty or its content moves on.
  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      vld_p              <= '0;
      data_p[STAGES-1]   <= '0;
      carry_p[STAGES-1]  <= 1'b0;
      tag_p[STAGES-1]    <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (in_Flush)     vld_p[k] <= 1'b0;
        else if (take[k]) vld_p[k] <= src_vld[k];
        if (take[k] && src_vld[k]) begin
          data_p[k]  <= nxt[k][WIDTH-1:0];
          carry_p[k] <= nxt[k][WIDTH];
          amt_p[k]   <= src_amt[k];
          typ_p[k]   <= src_typ[k];
          tag_p[k]   <= src_tag[k];
        end
      end
    end
  end

  assign out_Valid = vld_p[STAGES-1];
  assign out_Op2   = data_p[STAGES-1];
  assign out_Carry = carry_p[STAGES-1];
  assign out_Tag   = tag_p[STAGES-1];

`ifdef BSHIFT_FLAGS_EN
  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      out_Zero <= 1'b0;
      out_Neg  <= 1'b0;
    end else if (take[STAGES-1] && src_vld[STAGES-1]) begin
      out_Zero <= (nxt[STAGES-1][WIDTH-1:0] == '0);
      out_Neg  <= nxt[STAGES-1][WIDTH-1];
    end
  end
`else
  // Result flags are left to the consumer in this build.
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter (WIDTH=32, STAGES=2); checks flags when BSHIFT_FLAGS_EN is defined.
module tb_pipelined_barrel_shifter;

  logic        in_Clk = 1'b0;
  logic        in_Rst, in_Flush, in_Valid, in_Ready, in_Reg_mode, in_C_flag;
  logic [31:0] in_Val;
  logic [7:0]  in_Amount;
  logic [1:0]  in_Shift_type;
  logic [3:0]  in_Tag;
  logic        out_Ready, out_Valid, out_Carry;
  logic [31:0] out_Op2;
  logic [3:0]  out_Tag;
`ifdef BSHIFT_FLAGS_EN
  logic        out_Zero, out_Neg;
`endif

  int errors = 0;
  int checks = 0;
  int sent, rcvd, occ;
  logic acc, cons, prev_stall, h_c;
  logic [31:0] h_op2;
  logic [3:0]  h_tag;

  always #5 in_Clk = ~in_Clk;

  pipelined_barrel_shifter #(.WIDTH(32), .AMT_WIDTH(8), .STAGES(2), .TAG_WIDTH(4)) dut (
    .in_Clk(in_Clk), .in_Rst(in_Rst), .in_Flush(in_Flush), .in_Valid(in_Valid),
    .out_Ready(out_Ready), .in_Val(in_Val), .in_Amount(in_Amount),
    .in_Shift_type(in_Shift_type), .in_Reg_mode(in_Reg_mode), .in_C_flag(in_C_flag),
    .in_Tag(in_Tag), .out_Valid(out_Valid), .in_Ready(in_Ready), .out_Op2(out_Op2),
    .out_Carry(out_Carry), .out_Tag(out_Tag)
`ifdef BSHIFT_FLAGS_EN
    , .out_Zero(out_Zero), .out_Neg(out_Neg)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] val, input logic [7:0] amt, input logic [1:0] typ,
                       input logic rm, input logic c, input logic [3:0] tag);
    in_Val = val; in_Amount = amt; in_Shift_type = typ; in_Reg_mode = rm;
    in_C_flag = c; in_Tag = tag; in_Valid = 1'b1;
  endtask

  // One beat through an empty pipe: accepted at edge N, visible after edge N+1.
  task automatic run_beat(input string name, input logic [31:0] val, input logic [7:0] amt,
                          input logic [1:0] typ, input logic rm, input logic c,
                          input logic [3:0] tag, input logic [31:0] e_op2, input logic e_c);
    drive(val, amt, typ, rm, c, tag);
    in_Ready = 1'b1;
    #1;
    check({name, "_rdy"}, 32'(out_Ready), 32'd1);
    @(posedge in_Clk); #1;
    in_Valid = 1'b0;
    check({name, "_early"}, 32'(out_Valid), 32'd0);
    @(posedge in_Clk); #1;
    check({name, "_vld"}, 32'(out_Valid), 32'd1);
    check({name, "_op2"}, out_Op2, e_op2);
    check({name, "_c"}, 32'(out_Carry), 32'(e_c));
    check({name, "_tag"}, 32'(out_Tag), 32'(tag));
`ifdef BSHIFT_FLAGS_EN
    check({name, "_zero"}, 32'(out_Zero), 32'(e_op2 == 32'd0));
    check({name, "_neg"}, 32'(out_Neg), 32'(e_op2[31]));
`endif
    @(posedge in_Clk); #1;
  endtask

  initial begin
    in_Rst = 1'b1; in_Flush = 1'b0; in_Valid = 1'b0; in_Ready = 1'b1;
    in_Val = '0; in_Amount = '0; in_Shift_type = '0; in_Reg_mode = 1'b0;
    in_C_flag = 1'b0; in_Tag = '0;
    repeat (2) @(posedge in_Clk);
    #1;
    check("reset_vld", 32'(out_Valid), 32'd0);
    check("reset_op2", out_Op2, 32'd0);
    check("reset_c", 32'(out_Carry), 32'd0);
    check("reset_tag", 32'(out_Tag), 32'd0);
    in_Rst = 1'b0;
    @(posedge in_Clk); #1;

    // Immediate mode
    run_beat("imm_lsl4",  32'h1000_000F, 8'd4, 2'b00, 1'b0, 1'b0, 4'd1, 32'h0000_00F0, 1'b1);
    run_beat("imm_lsr0",  32'h8000_0000, 8'd0, 2'b01, 1'b0, 1'b0, 4'd2, 32'h0000_0000, 1'b1);
    run_beat("imm_asr0",  32'h8000_0000, 8'd0, 2'b10, 1'b0, 1'b0, 4'd3, 32'hFFFF_FFFF, 1'b1);
    run_beat("imm_rrx",   32'h0000_0003, 8'd0, 2'b11, 1'b0, 1'b1, 4'd4, 32'h8000_0001, 1'b1);
    run_beat("imm_ror8",  32'h0000_00AB, 8'd8, 2'b11, 1'b0, 1'b0, 4'd5, 32'hAB00_0000, 1'b1);
    run_beat("imm_asr4",  32'h8000_0010, 8'd4, 2'b10, 1'b0, 1'b1, 4'd6, 32'hF800_0001, 1'b0);
    run_beat("imm_lsl0",  32'h1234_5678, 8'd0, 2'b00, 1'b0, 1'b1, 4'd7, 32'h1234_5678, 1'b1);
    // Register mode
    run_beat("reg_lsl32", 32'h0000_0001, 8'd32, 2'b00, 1'b1, 1'b0, 4'd8, 32'h0000_0000, 1'b1);
    run_beat("reg_lsl33", 32'h0000_0001, 8'd33, 2'b00, 1'b1, 1'b1, 4'd9, 32'h0000_0000, 1'b0);
    run_beat("reg_ror32", 32'h8000_0001, 8'd32, 2'b11, 1'b1, 1'b0, 4'd10, 32'h8000_0001, 1'b1);
    run_beat("reg_ror36", 32'h0000_00F0, 8'd36, 2'b11, 1'b1, 1'b1, 4'd11, 32'h0000_000F, 1'b0);
    run_beat("reg_r0",    32'h1234_5678, 8'd0, 2'b01, 1'b1, 1'b1, 4'd12, 32'h1234_5678, 1'b1);
    run_beat("reg_lsr32", 32'h8000_0000, 8'd32, 2'b01, 1'b1, 1'b0, 4'd13, 32'h0000_0000, 1'b1);
    run_beat("reg_lsr5",  32'h0000_00F0, 8'd5, 2'b01, 1'b1, 1'b0, 4'd14, 32'h0000_0007, 1'b1);
    run_beat("reg_asr40", 32'h7000_0000, 8'd40, 2'b10, 1'b1, 1'b1, 4'd15, 32'h0000_0000, 1'b0);

    // Backpressure: 6 beats (LSL #1 of tag+1), in_Ready low on cycles 3..5
    sent = 0; rcvd = 0; occ = 0; prev_stall = 1'b0;
    for (int cyc = 0; cyc < 40 && rcvd < 6; cyc++) begin
      in_Ready = !(cyc >= 3 && cyc <= 5);
      in_Valid = (sent < 6);
      in_Tag = 4'(sent); in_Val = 32'(sent + 1); in_Amount = 8'd1;
      in_Shift_type = 2'b00; in_Reg_mode = 1'b0; in_C_flag = 1'b1;
      #1;
      check("bp_ready", 32'(out_Ready), 32'((occ < 2) || in_Ready));
      if (out_Valid && !in_Ready) begin
        if (prev_stall) begin
          check("bp_hold_op2", out_Op2, h_op2);
          check("bp_hold_c", 32'(out_Carry), 32'(h_c));
          check("bp_hold_tag", 32'(out_Tag), 32'(h_tag));
        end
        h_op2 = out_Op2; h_c = out_Carry; h_tag = out_Tag; prev_stall = 1'b1;
      end else prev_stall = 1'b0;
      cons = out_Valid && in_Ready;
      if (cons) begin
        check("bp_tag", 32'(out_Tag), 32'(rcvd));
        check("bp_op2", out_Op2, 32'((rcvd + 1) * 2));
        check("bp_c", 32'(out_Carry), 32'd0);
      end
      acc = in_Valid && out_Ready;
      @(posedge in_Clk); #1;
      if (acc) sent++;
      if (cons) rcvd++;
      occ = occ + int'(acc) - int'(cons);
    end
    in_Valid = 1'b0; in_Ready = 1'b1;
    check("bp_sent", 32'(sent), 32'd6);
    check("bp_count", 32'(rcvd), 32'd6);
    @(posedge in_Clk); #1;

    // Flush with two beats in flight and a new beat offered
    drive(32'h0000_0001, 8'd1, 2'b00, 1'b0, 1'b0, 4'd1);
    @(posedge in_Clk); #1;
    drive(32'h0000_0002, 8'd1, 2'b00, 1'b0, 1'b0, 4'd2);
    @(posedge in_Clk); #1;
    check("fl_pre_vld", 32'(out_Valid), 32'd1);
    check("fl_pre_tag", 32'(out_Tag), 32'd1);
    drive(32'h0000_0003, 8'd1, 2'b00, 1'b0, 1'b0, 4'd7);
    in_Flush = 1'b1;
    #1;
    check("fl_ready", 32'(out_Ready), 32'd0);
    @(posedge in_Clk); #1;
    in_Flush = 1'b0; in_Valid = 1'b0;
    check("fl_vld0", 32'(out_Valid), 32'd0);
    @(posedge in_Clk); #1;
    check("fl_drop", 32'(out_Valid), 32'd0);
    run_beat("fl_next", 32'h0000_0005, 8'd2, 2'b00, 1'b0, 1'b0, 4'd6, 32'h0000_0014, 1'b0);

    // Reset with two beats in flight
    drive(32'h8000_0000, 8'd0, 2'b10, 1'b0, 1'b0, 4'd9);
    @(posedge in_Clk); #1;
    drive(32'h8000_0000, 8'd0, 2'b10, 1'b0, 1'b0, 4'd10);
    @(posedge in_Clk); #1;
    check("rs_pre_vld", 32'(out_Valid), 32'd1);
    check("rs_pre_op2", out_Op2, 32'hFFFF_FFFF);
    in_Rst = 1'b1;
    @(posedge in_Clk); #1;
    in_Rst = 1'b0; in_Valid = 1'b0;
    check("rs_vld", 32'(out_Valid), 32'd0);
    check("rs_op2", out_Op2, 32'd0);
    check("rs_c", 32'(out_Carry), 32'd0);
    check("rs_tag", 32'(out_Tag), 32'd0);
`ifdef BSHIFT_FLAGS_EN
    check("rs_zero", 32'(out_Zero), 32'd0);
    check("rs_neg", 32'(out_Neg), 32'd0);
`endif
    @(posedge in_Clk); #1;
    check("rs_drop", 32'(out_Valid), 32'd0);
    run_beat("rs_next", 32'h0000_0003, 8'd1, 2'b01, 1'b0, 1'b0, 4'd3, 32'h0000_0001, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
